// File: rtl/bldc_speed_pi_pwm.sv
// Shift-gain PI speed regulator with anti-windup clamp and a glitch-free PWM
// whose duty is only reloaded at the period wrap.
module bldc_speed_pi_pwm #(
   parameter int unsigned ERR_W    = 9,
   parameter int unsigned DUTY_W   = 10,
   parameter int unsigned KP_SHIFT = 2,
   parameter int unsigned KI_SHIFT = 4,
   parameter int          DUTY_MIN = 0,
   parameter int          DUTY_MAX = 1000,
   parameter int unsigned PWM_TOP  = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ERR_W-1:0]  err,
   input  logic              err_valid,
   input  logic              ovr_clr,
   output logic              busy,
   output logic              upd_done,
   output logic [DUTY_W-1:0] duty_cmd,
   output logic              overrun,
   output logic              pwm_out
);

   localparam int unsigned AW = DUTY_W + 3;
   localparam logic signed [AW-1:0] MIN_S = AW'(DUTY_MIN);
   localparam logic signed [AW-1:0] MAX_S = AW'(DUTY_MAX);
   localparam logic [DUTY_W-1:0]    TOP   = DUTY_W'(PWM_TOP);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_SAT, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic        [ERR_W-1:0]  err_q, err_d;
   logic signed [AW-1:0]     p_q, p_d;
   logic signed [AW-1:0]     inxt_q, inxt_d;
   logic signed [AW-1:0]     integ_q, integ_d;
   logic        [DUTY_W-1:0] duty_cmd_q, duty_cmd_d;
   logic        [DUTY_W-1:0] duty_act_q, duty_act_d;
   logic        [DUTY_W-1:0] cnt_q, cnt_d;
   logic                     upd_q, upd_d;
   logic                     ovr_q, ovr_d;
   logic                     pwm_q, pwm_d;

   logic signed [AW-1:0]     err_x;
   logic signed [AW-1:0]     isat;
   logic signed [AW-1:0]     dsat;

   function automatic logic signed [AW-1:0] clamp(input logic signed [AW-1:0] v);
      if (v < MIN_S) return MIN_S;
      if (v > MAX_S) return MAX_S;
      return v;
   endfunction

   assign err_x = {{(AW-ERR_W){err_q[ERR_W-1]}}, err_q};
   assign isat  = clamp(inxt_q);
   assign dsat  = clamp(isat + p_q);

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      p_d        = p_q;
      inxt_d     = inxt_q;
      integ_d    = integ_q;
      duty_cmd_d = duty_cmd_q;
      upd_d      = 1'b0;
      ovr_d      = ovr_q;
      if (ovr_clr) ovr_d = 1'b0;
      if (!en) begin
         state_d    = S_IDLE;
         integ_d    = '0;
         duty_cmd_d = '0;
      end else begin
         // set is evaluated after clear so a coincident drop keeps the flag
         if (err_valid && (state_q != S_IDLE)) ovr_d = 1'b1;
         unique case (state_q)
            S_IDLE: if (err_valid) begin
               err_d   = err;
               state_d = S_CALC;
            end
            S_CALC: begin
               p_d     = err_x >>> KP_SHIFT;
               inxt_d  = integ_q + (err_x >>> KI_SHIFT);
               state_d = S_SAT;
            end
            S_SAT: begin
               integ_d    = isat;
               duty_cmd_d = DUTY_W'(dsat);
               upd_d      = 1'b1;
               state_d    = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d      = '0;
      duty_act_d = '0;
      pwm_d      = 1'b0;
      if (en) begin
         cnt_d      = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;
         duty_act_d = (cnt_q == TOP) ? duty_cmd_q : duty_act_q;
         pwm_d      = (cnt_q < duty_act_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         err_q      <= '0;
         p_q        <= '0;
         inxt_q     <= '0;
         integ_q    <= '0;
         duty_cmd_q <= '0;
         duty_act_q <= '0;
         cnt_q      <= '0;
         upd_q      <= 1'b0;
         ovr_q      <= 1'b0;
         pwm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         p_q        <= p_d;
         inxt_q     <= inxt_d;
         integ_q    <= integ_d;
         duty_cmd_q <= duty_cmd_d;
         duty_act_q <= duty_act_d;
         cnt_q      <= cnt_d;
         upd_q      <= upd_d;
         ovr_q      <= ovr_d;
         pwm_q      <= pwm_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign upd_done = upd_q;
   assign duty_cmd = duty_cmd_q;
   assign overrun  = ovr_q;
   assign pwm_out  = pwm_q;

endmodule
